// File: rtl/toy_pack.sv
// Shared widths, starvation limit and arbiter state encoding for the
// instruction-cache tag RAM port arbiter.
package toy_pack;

   localparam int ICACHE_INDEX_WIDTH          = 6;
   localparam int ICACHE_TAG_RAM_WIDTH        = 40;
   localparam int ICACHE_TAG_STARVE_LIMIT     = 4;
   localparam int ICACHE_TAG_STARVE_CNT_WIDTH = $clog2(ICACHE_TAG_STARVE_LIMIT) + 1;

   // Each tag word packs two ways; each way keeps its valid flag in its top bit.
   localparam int ICACHE_WAY0_VALID_BIT = ICACHE_TAG_RAM_WIDTH - 1;
   localparam int ICACHE_WAY1_VALID_BIT = ICACHE_TAG_RAM_WIDTH / 2 - 1;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_INV_RD = 2'd1,
      ARB_INV_WR = 2'd2
   } tag_arb_state_t;

   function automatic logic [ICACHE_TAG_RAM_WIDTH-1:0] way_valid_mask(input logic way);
      way_valid_mask = '0;
      if (way) way_valid_mask[ICACHE_WAY1_VALID_BIT] = 1'b1;
      else     way_valid_mask[ICACHE_WAY0_VALID_BIT] = 1'b1;
   endfunction

endpackage

// File: rtl/icache_tag_port_arb.sv
// Arbitrates the single-port icache tag RAM between miss fills, snoop
// invalidates (read-modify-write) and lookups, with lookup anti-starvation.
module icache_tag_port_arb
   import toy_pack::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wr_vld,
   output logic                            wr_rdy,
   input  logic [ICACHE_INDEX_WIDTH-1:0]   wr_index,
   input  logic [ICACHE_TAG_RAM_WIDTH-1:0] wr_data,
   input  logic                            inv_vld,
   output logic                            inv_rdy,
   input  logic [ICACHE_INDEX_WIDTH-1:0]   inv_index,
   input  logic                            inv_way,
   output logic                            inv_done,
   input  logic                            lk_vld,
   output logic                            lk_rdy,
   input  logic [ICACHE_INDEX_WIDTH-1:0]   lk_index,
   output logic                            lk_rsp_vld,
   output logic [ICACHE_TAG_RAM_WIDTH-1:0] lk_rsp_data,
   output logic                            mem_en,
   output logic                            mem_wr_en,
   output logic [ICACHE_INDEX_WIDTH-1:0]   mem_addr,
   output logic [ICACHE_TAG_RAM_WIDTH-1:0] mem_wr_data,
   input  logic [ICACHE_TAG_RAM_WIDTH-1:0] mem_rd_data,
   output logic                            busy
);

   localparam int IW = ICACHE_INDEX_WIDTH;
   localparam int TW = ICACHE_TAG_RAM_WIDTH;
   localparam int CW = ICACHE_TAG_STARVE_CNT_WIDTH;
   localparam logic [CW-1:0] STARVE_MAX = CW'(ICACHE_TAG_STARVE_LIMIT);

   tag_arb_state_t r_state;
   tag_arb_state_t w_state_nxt;
   logic [CW-1:0]  r_starve_cnt;
   logic           r_lk_pend;
   logic [IW-1:0]  r_inv_index;
   logic           r_inv_way;
   logic [TW-1:0]  r_inv_data;

   logic           w_starve;
   logic           w_wr_rdy;
   logic           w_inv_rdy;
   logic           w_lk_rdy;
   logic           w_inv_done;
   logic           w_mem_en;
   logic           w_mem_wr_en;
   logic [IW-1:0]  w_mem_addr;
   logic [TW-1:0]  w_mem_wr_data;
   logic           w_lk_hs;
   logic           w_inv_hs;

   assign w_starve = (r_starve_cnt == STARVE_MAX);
   assign w_lk_hs  = lk_vld && w_lk_rdy;
   assign w_inv_hs = inv_vld && w_inv_rdy;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
      w_state_nxt   = r_state;
      w_wr_rdy      = 1'b0;
      w_inv_rdy     = 1'b0;
      w_lk_rdy      = 1'b0;
      w_inv_done    = 1'b0;
      w_mem_en      = 1'b0;
      w_mem_wr_en   = 1'b0;
      w_mem_addr    = '0;
      w_mem_wr_data = '0;

      if (!rst_n) begin
         w_state_nxt = ARB_IDLE;
      end else begin
         unique case (r_state)
            ARB_IDLE: begin
               if (lk_vld && w_starve) w_lk_rdy  = 1'b1;
               else if (wr_vld)        w_wr_rdy  = 1'b1;
               else if (inv_vld)       w_inv_rdy = 1'b1;
               else if (lk_vld)        w_lk_rdy  = 1'b1;

               if (w_wr_rdy) begin
                  w_mem_en      = 1'b1;
                  w_mem_wr_en   = 1'b1;
                  w_mem_addr    = wr_index;
                  w_mem_wr_data = wr_data;
               end else if (w_inv_rdy) begin
                  w_mem_en    = 1'b1;
                  w_mem_addr  = inv_index;
                  w_state_nxt = ARB_INV_RD;
               end else if (w_lk_rdy) begin
                  w_mem_en   = 1'b1;
                  w_mem_addr = lk_index;
               end
            end
            ARB_INV_RD: begin
               w_state_nxt = ARB_INV_WR;
            end
            ARB_INV_WR: begin
               w_mem_en      = 1'b1;
               w_mem_wr_en   = 1'b1;
               w_mem_addr    = r_inv_index;
               w_mem_wr_data = r_inv_data & ~way_valid_mask(r_inv_way);
               w_inv_done    = 1'b1;
               w_state_nxt   = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ARB_IDLE;
         r_starve_cnt <= '0;
         r_lk_pend    <= 1'b0;
         r_inv_index  <= '0;
         r_inv_way    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lk_pend <= w_lk_hs;
         if (!lk_vld || w_lk_hs)          r_starve_cnt <= '0;
         else if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
         if (w_inv_hs) begin
            r_inv_index <= inv_index;
            r_inv_way   <= inv_way;
         end
      end
   end

   // NOTE: r_inv_data is pure datapath, always loaded before use, so it carries no reset.
   always_ff @(posedge clk) begin
      if (r_state == ARB_INV_RD) r_inv_data <= mem_rd_data;
   end

   assign wr_rdy      = w_wr_rdy;
   assign inv_rdy     = w_inv_rdy;
   assign lk_rdy      = w_lk_rdy;
   assign inv_done    = w_inv_done;
   assign mem_en      = w_mem_en;
   assign mem_wr_en   = w_mem_wr_en;
   assign mem_addr    = w_mem_addr;
   assign mem_wr_data = w_mem_wr_data;
   assign busy        = rst_n && (r_state != ARB_IDLE);
   assign lk_rsp_vld  = rst_n && r_lk_pend;
   assign lk_rsp_data = lk_rsp_vld ? mem_rd_data : '0;

endmodule

// File: tb/tb_icache_tag_port_arb.sv
// Bench for icache_tag_port_arb: tag RAM model, per-cycle reference model
// comparison, and directed scenarios with hand-computed expectations.
module tb_icache_tag_port_arb;
   import toy_pack::*;

   localparam int IW    = ICACHE_INDEX_WIDTH;
   localparam int TW    = ICACHE_TAG_RAM_WIDTH;
   localparam int LIMIT = ICACHE_TAG_STARVE_LIMIT;

   logic          clk;
   logic          rst_n;
   logic          wr_vld, wr_rdy;
   logic [IW-1:0] wr_index;
   logic [TW-1:0] wr_data;
   logic          inv_vld, inv_rdy, inv_way, inv_done;
   logic [IW-1:0] inv_index;
   logic          lk_vld, lk_rdy, lk_rsp_vld;
   logic [IW-1:0] lk_index;
   logic [TW-1:0] lk_rsp_data;
   logic          mem_en, mem_wr_en, busy;
   logic [IW-1:0] mem_addr;
   logic [TW-1:0] mem_wr_data, mem_rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [TW-1:0] ram [0:(1<<IW)-1];

   icache_tag_port_arb dut (
      .clk(clk), .rst_n(rst_n),
      .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_index(wr_index), .wr_data(wr_data),
      .inv_vld(inv_vld), .inv_rdy(inv_rdy), .inv_index(inv_index), .inv_way(inv_way),
      .inv_done(inv_done),
      .lk_vld(lk_vld), .lk_rdy(lk_rdy), .lk_index(lk_index),
      .lk_rsp_vld(lk_rsp_vld), .lk_rsp_data(lk_rsp_data),
      .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [TW-1:0] init_word(input int i);
      if (i == 5 || i == 7) return 40'h80_0000_8001;
      if (i == 10)          return 40'hFF_FFFF_FFFF;
      return 40'h12_3400_0000 ^ (TW'(i) * 40'h00_0101_0101);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Tag RAM: one-cycle read latency, read data held while not re-read.
   initial begin
      for (int i = 0; i < (1<<IW); i++) ram[i] = init_word(i);
      mem_rd_data = '0;
      forever begin
         @(posedge clk);
         if (mem_en) begin
            if (mem_wr_en) ram[mem_addr] = mem_wr_data;
            else           mem_rd_data  <= ram[mem_addr];
         end
      end
   end

   // Reference model: the port grant decided from priority rules, invalidate
   // tracked as a cycle phase, expected RAM contents kept in a shadow array.
   logic [TW-1:0] shadow [0:(1<<IW)-1];
   int            m_phase = 0;
   int            m_waits = 0;
   bit            m_pend  = 0;
   logic [TW-1:0] m_pend_data = '0;
   logic [IW-1:0] m_inv_idx = '0;
   bit            m_inv_way = 0;

   initial begin
      bit            lk_g, wr_g, inv_g;
      logic [TW-1:0] e_wdata, clr;
      logic [IW-1:0] e_addr;
      bit            e_en, e_wen, e_done, e_busy, e_rvld;
      logic [TW-1:0] e_rdata;
      for (int i = 0; i < (1<<IW); i++) shadow[i] = init_word(i);
      forever begin
         @(negedge clk);
         lk_g = 0; wr_g = 0; inv_g = 0;
         e_en = 0; e_wen = 0; e_done = 0; e_busy = 0; e_rvld = 0;
         e_rdata = '0; e_addr = '0; e_wdata = '0;
         clr = TW'(1) << (m_inv_way ? (TW/2 - 1) : (TW - 1));
         if (rst_n) begin
            e_busy = (m_phase != 0);
            if (m_phase == 0) begin
               if (lk_vld && m_waits >= LIMIT) lk_g = 1;
               else if (wr_vld)                wr_g = 1;
               else if (inv_vld)               inv_g = 1;
               else if (lk_vld)                lk_g = 1;
            end
            e_done = (m_phase == 2);
            e_en   = wr_g || inv_g || lk_g || e_done;
            e_wen  = wr_g || e_done;
            e_addr = wr_g ? wr_index : inv_g ? inv_index : lk_g ? lk_index : m_inv_idx;
            e_wdata = wr_g ? wr_data : (shadow[m_inv_idx] & ~clr);
            e_rvld  = m_pend;
            e_rdata = m_pend ? m_pend_data : '0;
         end
         check("model wr_rdy", 64'(wr_rdy), 64'(wr_g));
         check("model inv_rdy", 64'(inv_rdy), 64'(inv_g));
         check("model lk_rdy", 64'(lk_rdy), 64'(lk_g));
         check("model busy", 64'(busy), 64'(e_busy));
         check("model inv_done", 64'(inv_done), 64'(e_done));
         check("model mem_en", 64'(mem_en), 64'(e_en));
         check("model lk_rsp_vld", 64'(lk_rsp_vld), 64'(e_rvld));
         check("model lk_rsp_data", 64'(lk_rsp_data), 64'(e_rdata));
         if (e_en) begin
            check("model mem_wr_en", 64'(mem_wr_en), 64'(e_wen));
            check("model mem_addr", 64'(mem_addr), 64'(e_addr));
            if (e_wen) check("model mem_wr_data", 64'(mem_wr_data), 64'(e_wdata));
         end
         // Advance the model to the state after the coming rising edge.
         if (!rst_n) begin
            m_phase = 0; m_waits = 0; m_pend = 0; m_inv_idx = '0; m_inv_way = 0;
         end else begin
            m_pend = lk_g;
            if (lk_g) m_pend_data = shadow[lk_index];
            if (lk_vld && !lk_g) m_waits = (m_waits + 1 > LIMIT) ? LIMIT : m_waits + 1;
            else                 m_waits = 0;
            if (wr_g) shadow[wr_index] = wr_data;
            case (m_phase)
               0: if (inv_g) begin m_phase = 1; m_inv_idx = inv_index; m_inv_way = inv_way; end
               1: m_phase = 2;
               default: begin shadow[m_inv_idx] = e_wdata; m_phase = 0; end
            endcase
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_vld = 0; inv_vld = 0; lk_vld = 0;
   endtask

   initial begin
      logic [63:0] rnd;
      rst_n = 0; idle_inputs();
      wr_index = 3; wr_data = '0; inv_index = '0; inv_way = 0; lk_index = '0;
      wr_vld = 1;
      #2;
      check("reset wr_rdy", 64'(wr_rdy), 64'd0);
      check("reset mem_en", 64'(mem_en), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset lk_rsp_vld", 64'(lk_rsp_vld), 64'd0);
      cyc(); cyc();

      // Write beats lookup, lookup starves for 4 cycles, then wins once.
      rst_n = 1; wr_vld = 1; wr_index = 3; wr_data = 40'h12_3456_789A;
      lk_vld = 1; lk_index = 5;
      #1;
      check("c1 wr_rdy", 64'(wr_rdy), 64'd1);
      check("c1 mem_wr_en", 64'(mem_wr_en), 64'd1);
      check("c1 mem_addr", 64'(mem_addr), 64'd3);
      check("c1 lk_rdy", 64'(lk_rdy), 64'd0);
      for (int c = 2; c <= 4; c++) begin
         cyc(); #1;
         check("starve wait wr_rdy", 64'(wr_rdy), 64'd1);
         check("starve wait lk_rdy", 64'(lk_rdy), 64'd0);
      end
      cyc(); #1;
      check("c5 lk_rdy", 64'(lk_rdy), 64'd1);
      check("c5 wr_rdy", 64'(wr_rdy), 64'd0);
      check("c5 mem_wr_en", 64'(mem_wr_en), 64'd0);
      check("c5 mem_addr", 64'(mem_addr), 64'd5);
      cyc(); #1;
      check("c6 lk_rsp_vld", 64'(lk_rsp_vld), 64'd1);
      check("c6 lk_rsp_data", 64'(lk_rsp_data), 64'h80_0000_8001);
      check("c6 wr_rdy", 64'(wr_rdy), 64'd1);
      cyc(); idle_inputs(); #1;
      check("c7 lk_rsp_vld", 64'(lk_rsp_vld), 64'd0);
      check("c7 lk_rsp_data", 64'(lk_rsp_data), 64'd0);

      // Invalidate way 0 of index 7 while write and lookup queue behind it.
      cyc(); inv_vld = 1; inv_index = 7; inv_way = 0; #1;
      check("inv grant inv_rdy", 64'(inv_rdy), 64'd1);
      check("inv grant busy", 64'(busy), 64'd0);
      check("inv grant mem_wr_en", 64'(mem_wr_en), 64'd0);
      check("inv grant mem_addr", 64'(mem_addr), 64'd7);
      cyc(); inv_vld = 0; wr_vld = 1; wr_index = 9; wr_data = 40'h0A_0B0C_0D0E;
      lk_vld = 1; lk_index = 5; #1;
      check("inv_rd busy", 64'(busy), 64'd1);
      check("inv_rd mem_en", 64'(mem_en), 64'd0);
      check("inv_rd rdy", 64'({wr_rdy, lk_rdy, inv_rdy}), 64'd0);
      cyc(); #1;
      check("inv_wr busy", 64'(busy), 64'd1);
      check("inv_wr inv_done", 64'(inv_done), 64'd1);
      check("inv_wr mem_addr", 64'(mem_addr), 64'd7);
      check("inv_wr mem_wr_data", 64'(mem_wr_data), 64'h00_0000_8001);
      check("inv_wr rdy", 64'({wr_rdy, lk_rdy, inv_rdy}), 64'd0);
      cyc(); #1;
      check("post inv busy", 64'(busy), 64'd0);
      check("post inv wr_rdy", 64'(wr_rdy), 64'd1);
      check("post inv inv_done", 64'(inv_done), 64'd0);
      check("ram7 after inv", 64'(ram[7]), 64'h00_0000_8001);

      // Clear way 1 of a fully valid word, then re-invalidate an invalid way.
      cyc(); idle_inputs(); inv_vld = 1; inv_index = 10; inv_way = 1;
      cyc(); inv_vld = 0;
      cyc(); #1;
      check("way1 inv_done", 64'(inv_done), 64'd1);
      check("way1 mem_wr_data", 64'(mem_wr_data), 64'hFF_FFF7_FFFF);
      cyc(); #1;
      check("ram10 after way1", 64'(ram[10]), 64'hFF_FFF7_FFFF);
      inv_vld = 1; inv_index = 7; inv_way = 1;
      cyc(); inv_vld = 0;
      cyc(); #1;
      check("reinv inv_done", 64'(inv_done), 64'd1);
      check("reinv mem_wr_data", 64'(mem_wr_data), 64'h00_0000_8001);

      // Reset during INV_RD aborts the sequence.
      cyc(); inv_vld = 1; inv_index = 10; inv_way = 0;
      cyc(); inv_vld = 0; rst_n = 0; #1;
      check("abort busy in reset", 64'(busy), 64'd0);
      check("abort mem_en in reset", 64'(mem_en), 64'd0);
      cyc(); rst_n = 1; #1;
      check("abort busy after", 64'(busy), 64'd0);
      check("abort inv_done after", 64'(inv_done), 64'd0);
      for (int c = 0; c < 3; c++) begin
         cyc(); #1;
         check("abort no inv_done", 64'(inv_done), 64'd0);
      end
      check("ram10 untouched", 64'(ram[10]), 64'hFF_FFF7_FFFF);

      // Mixed traffic checked by the reference model every cycle.
      for (int c = 0; c < 400; c++) begin
         cyc();
         rst_n     = ($urandom_range(0, 99) != 0);
         wr_vld    = ($urandom_range(0, 2) == 0);
         inv_vld   = ($urandom_range(0, 4) == 0);
         lk_vld    = ($urandom_range(0, 1) == 0);
         wr_index  = IW'($urandom_range(0, 15));
         inv_index = IW'($urandom_range(0, 15));
         lk_index  = IW'($urandom_range(0, 15));
         inv_way   = 1'($urandom_range(0, 1));
         rnd       = {$urandom, $urandom};
         wr_data   = rnd[TW-1:0];
      end
      cyc(); idle_inputs(); rst_n = 1;
      cyc(); cyc(); cyc();
      @(negedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_tag_port_arb.md
ICACHE_TAG_PORT_ARB -- requirements
Module: icache_tag_port_arb

Interface
REQ-001 The block SHALL take its parameters from toy_pack, one per line: name, default, meaning:
  ICACHE_INDEX_WIDTH  6   tag RAM address width (IW)
  ICACHE_TAG_RAM_WIDTH  40   two-way tag RAM word width (TW); way0 valid bit = TW-1, way1 valid bit = TW/2-1
  ICACHE_TAG_STARVE_LIMIT  4   consecutive lookup-wait cycles before lookup gets top priority
REQ-002 One clock; reset is synchronous and active-low. Ports, one per line: name, direction, width, meaning:
  clk  in  1  clock
  rst_n  in  1  synchronous active-low reset
  wr_vld  in  1  tag write request (miss fill)
  wr_rdy  out  1  tag write granted this cycle
  wr_index  in  IW  tag write address
  wr_data  in  TW  tag write word
  inv_vld  in  1  snoop invalidate request
  inv_rdy  out  1  invalidate accepted this cycle
  inv_index  in  IW  invalidate address
  inv_way  in  1  way to invalidate (0/1)
  inv_done  out  1  pulse: invalidate write issued
  lk_vld  in  1  lookup read request
  lk_rdy  out  1  lookup granted this cycle
  lk_index  in  IW  lookup address
  lk_rsp_vld  out  1  lookup read data valid
  lk_rsp_data  out  TW  lookup read data
  mem_en  out  1  tag RAM enable
  mem_wr_en  out  1  tag RAM write (1) / read (0)
  mem_addr  out  IW  tag RAM address
  mem_wr_data  out  TW  tag RAM write data
  mem_rd_data  in  TW  tag RAM read data, 1-cycle latency after read enable
  busy  out  1  invalidate sequence in progress

Function
REQ-003 The single-port tag RAM SHALL be driven by at most one requester per cycle; a handshake is vld&&rdy in the same cycle, and each rdy is combinational from vld and state.
REQ-004 FSM states SHALL be IDLE, INV_RD, INV_WR; only IDLE grants new requests.
REQ-005 In IDLE, priority SHALL be: lookup if starve flag set, else wr > inv > lk; exactly one rdy asserts when any vld is high, none otherwise.
REQ-006 Write grant SHALL drive mem_en=1, mem_wr_en=1, mem_addr=wr_index, mem_wr_data=wr_data in the grant cycle; state stays IDLE.
REQ-007 Lookup grant SHALL drive mem_en=1, mem_wr_en=0, mem_addr=lk_index; lk_rsp_vld=1 and lk_rsp_data=mem_rd_data exactly one cycle later, else lk_rsp_vld=0 and lk_rsp_data=0.
REQ-008 Invalidate grant SHALL capture inv_index/inv_way, issue a read of inv_index in the grant cycle, and move IDLE->INV_RD.
REQ-009 INV_RD SHALL hold the port (all rdy=0, mem_en=0) and move to INV_WR unconditionally.
REQ-010 INV_WR SHALL write mem_rd_data to the captured index with only the selected way valid bit cleared, pulse inv_done, and return to IDLE; all rdy=0 this cycle.
REQ-011 busy SHALL be 1 in INV_RD and INV_WR, 0 in IDLE.
REQ-012 Starve counter (width clog2(LIMIT)+1) SHALL increment each cycle lk_vld&&!lk_rdy, saturate at LIMIT, clear on lookup handshake or lk_vld=0; starve flag = counter==LIMIT.
REQ-013 Invalidating an already-invalid way SHALL still perform the full 3-cycle sequence and pulse inv_done.
REQ-014 Requests arriving during INV_RD/INV_WR SHALL wait; lookup waits count toward starvation.

Reset
REQ-015 On rst_n=0 at a clock edge: state=IDLE, starve counter=0, captured index/way=0; all outputs 0 while reset is low.
REQ-016 Reset during INV_RD or INV_WR SHALL abort the sequence with no RAM write and no inv_done pulse.

Structure
REQ-017 Width constants, ICACHE_TAG_STARVE_LIMIT and enum tag_arb_state_t SHALL live in toy_pack.
REQ-018 No sub-module; the tag RAM (toy_mem_model_bit) SHALL be instantiated by the parent, outside this block.

Verification
REQ-019 wr_vld and lk_vld both high, counter 0, wr_index=3 -> wr_rdy=1, mem_wr_en=1, mem_addr=3, lk_rdy=0.
REQ-020 lk_vld with lk_index=5, RAM[5]=0x8000008001 -> lk_rsp_vld=1 one cycle later with data 0x8000008001.
REQ-021 inv_vld with index 7, way 0, RAM[7]=0x8000008001 -> busy for 2 cycles, inv_done in cycle 3, RAM[7]=0x0000008001.
REQ-022 wr_vld held high continuously plus lk_vld -> lk_rdy on the 5th cycle (after 4 waits), then wr regains port.
REQ-023 inv grant, then wr_vld and lk_vld high -> no rdy in INV_RD/INV_WR; wr_rdy first cycle back in IDLE.
REQ-024 rst_n=0 in INV_RD -> next cycle IDLE, busy=0, no write, inv_done never pulses.
